// File: rtl/add_unit_scheduler_pkg.sv
// rtl/add_unit_scheduler_pkg.sv - shared widths and pipeline record types for the add unit scheduler
package add_unit_scheduler_pkg;

    localparam int DATA_W      = 32;
    localparam int NUM_REQ_DEF = 4;
    localparam int TAG_W_DEF   = 4;

    // Stage 1: operands as presented to the adder; b is already inverted for subtract.
    typedef struct packed {
        logic                 valid;
        logic [DATA_W-1:0]    a;
        logic [DATA_W-1:0]    b_eff;
        logic                 cin;
        logic [TAG_W_DEF-1:0] tag;
    } s1_rec_t;

    // Stage 2: finished result waiting for the common data bus.
    typedef struct packed {
        logic                 valid;
        logic [DATA_W-1:0]    data;
        logic                 carry;
        logic [TAG_W_DEF-1:0] tag;
    } s2_rec_t;

endpackage

// File: rtl/add_unit_scheduler_rr_arbiter.sv
// rtl/add_unit_scheduler_rr_arbiter.sv - round-robin grant: first set request at or after ptr
// Ports: req (NUM_REQ) and ptr in; grant (one-hot, zero when no request) and grant_idx out.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx
);

    always_comb begin
        int         idx;
        logic       found;
        logic [PTR_W-1:0] idx_v;
        idx       = 0;
        idx_v     = '0;
        found     = 1'b0;
        grant     = '0;
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_v = PTR_W'(idx);
            if (!found && req[idx_v]) begin
                found        = 1'b1;
                grant[idx_v] = 1'b1;
                grant_idx    = idx_v;
            end
        end
    end

endmodule

// File: rtl/cla_adder_32.sv
// rtl/cla_adder_32.sv - 32-bit carry-lookahead adder, 4-bit lookahead groups
// Ports: a, b, cin in; sum, cout out. Purely combinational.
module cla_adder_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        int   b0;
        logic gg;
        logic pp;
        b0   = 0;
        gg   = 1'b0;
        pp   = 1'b0;
        c    = '0;
        c[0] = cin;
        for (int grp = 0; grp < 8; grp++) begin
            b0 = 4 * grp;
            c[b0+1] = g[b0] | (p[b0] & c[b0]);
            c[b0+2] = g[b0+1] | (p[b0+1] & g[b0]) | (p[b0+1] & p[b0] & c[b0]);
            c[b0+3] = g[b0+2] | (p[b0+2] & g[b0+1]) | (p[b0+2] & p[b0+1] & g[b0])
                    | (p[b0+2] & p[b0+1] & p[b0] & c[b0]);
            // Group generate/propagate lets the carry skip the whole nibble.
            gg = g[b0+3] | (p[b0+3] & g[b0+2]) | (p[b0+3] & p[b0+2] & g[b0+1])
               | (p[b0+3] & p[b0+2] & p[b0+1] & g[b0]);
            pp = &p[b0 +: 4];
            c[b0+4] = gg | (pp & c[b0]);
        end
    end

    assign sum  = p ^ c[31:0];
    assign cout = c[32];

endmodule

// File: rtl/add_unit_scheduler.sv
// rtl/add_unit_scheduler.sv - two-stage add/sub unit shared by NUM_REQ reservation stations
// Ports: clk, rst_n (async, active-low); per-requester req_valid/req_ready/req_a/req_b/req_sub/req_tag;
//        flush; result side res_valid/res_ready/res_data/res_carry/res_tag; busy.
module add_unit_scheduler
    import add_unit_scheduler_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int TAG_W   = TAG_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*32-1:0]    req_a,
    input  logic [NUM_REQ*32-1:0]    req_b,
    input  logic [NUM_REQ-1:0]       req_sub,
    input  logic [NUM_REQ*TAG_W-1:0] req_tag,
    input  logic                     flush,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [31:0]              res_data,
    output logic                     res_carry,
    output logic [TAG_W-1:0]         res_tag,
    output logic                     busy
);

    localparam int PTR_W = $clog2(NUM_REQ);

    s1_rec_t          s1;
    s2_rec_t          s2;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] rr_next;

    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   grant_idx;
    logic               s2_adv;
    logic               s1_accept;
    logic               xfer;

    logic [DATA_W-1:0]  sel_a;
    logic [DATA_W-1:0]  sel_b;
    logic               sel_sub;
    logic [TAG_W-1:0]   sel_tag;

    logic [DATA_W-1:0]  sum;
    logic               cout;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    cla_adder_32 u_cla (
        .a    (s1.a),
        .b    (s1.b_eff),
        .cin  (s1.cin),
        .sum  (sum),
        .cout (cout)
    );

    assign s2_adv    = !s2.valid || res_ready;
    assign s1_accept = !s1.valid || s2_adv;

    // rst_n gates the grant so nothing appears accepted while the pipeline is held in reset.
    assign req_ready = (rst_n && !flush && s1_accept) ? grant : '0;
    assign xfer      = |req_ready;

    assign sel_a   = req_a[grant_idx*DATA_W +: DATA_W];
    assign sel_b   = req_b[grant_idx*DATA_W +: DATA_W];
    assign sel_sub = req_sub[grant_idx];
    assign sel_tag = req_tag[grant_idx*TAG_W +: TAG_W];

    always_comb begin
        rr_next = '0;
        if (grant_idx != PTR_W'(NUM_REQ - 1)) begin
            rr_next = grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= '0;
            s2     <= '0;
            rr_ptr <= '0;
        end else if (flush) begin
            s1.valid <= 1'b0;
            s2.valid <= 1'b0;
        end else begin
            if (s2_adv) begin
                s2.valid <= s1.valid;
                s2.data  <= sum;
                s2.carry <= cout;
                s2.tag   <= s1.tag;
            end
            if (s1_accept) begin
                s1.valid <= xfer;
                if (xfer) begin
                    s1.a     <= sel_a;
                    // Subtract is a + ~b + 1, so the inversion and carry-in are fixed at issue.
                    s1.b_eff <= sel_sub ? ~sel_b : sel_b;
                    s1.cin   <= sel_sub;
                    s1.tag   <= TAG_W_DEF'(sel_tag);
                end
            end
            if (xfer) begin
                rr_ptr <= rr_next;
            end
        end
    end

    assign res_valid = s2.valid;
    assign res_data  = s2.data;
    assign res_carry = s2.carry;
    assign res_tag   = TAG_W'(s2.tag);
    assign busy      = s1.valid || s2.valid;

endmodule
